// File: rtl/twiddle_pkg.sv
// Shared constants and types for the twiddle ROM arbiter.
// Optional conjugate support is enabled with the TWIDDLE_CONJ_EN macro.
package twiddle_pkg;

    localparam int PHASE_W    = 12;
    localparam int DATA_W     = 16;
    localparam int ROM_ADDR_W = 11;

    localparam logic [ROM_ADDR_W-1:0] QUARTER  = 11'd1024;
    localparam logic [DATA_W-1:0]     ROM_PEAK = 16'h7fff;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD_A = 2'd1,
        RD_B = 2'd2,
        CAP  = 2'd3
    } state_e;

    // Two's complement negate when requested; -0 stays 0, -0x7fff becomes 0x8001.
    function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] x, input logic neg);
        return neg ? (-x) : x;
    endfunction

endpackage

// File: rtl/twiddle_quadrant_map.sv
// Folds a full-circle phase onto the quarter-wave ROM: picks the sin/cos
// addresses and tells the caller which of the two results to negate.
import twiddle_pkg::*;

module twiddle_quadrant_map (
    input  logic [PHASE_W-1:0]    phase,
    output logic [ROM_ADDR_W-1:0] sin_addr,
    output logic [ROM_ADDR_W-1:0] cos_addr,
    output logic                  neg_sin,
    output logic                  neg_cos
);

    logic [1:0]            quad;
    logic [ROM_ADDR_W-1:0] r_ext;
    logic [ROM_ADDR_W-1:0] r_mir;

    assign quad  = phase[PHASE_W-1 -: 2];
    assign r_ext = {1'b0, phase[PHASE_W-3:0]};
    // r = 0 mirrors to 1024, the ROM peak entry
    assign r_mir = QUARTER - r_ext;

    // Quadrant symmetry: odd quadrants swap the addresses, sign follows the quadrant
    always_comb begin
        sin_addr = r_ext;
        cos_addr = r_mir;
        neg_sin  = 1'b0;
        neg_cos  = 1'b0;
        case (quad)
            Q0: ;
            Q1: begin
                sin_addr = r_mir;
                cos_addr = r_ext;
                neg_cos  = 1'b1;
            end
            Q2: begin
                neg_sin = 1'b1;
                neg_cos = 1'b1;
            end
            Q3: begin
                sin_addr = r_mir;
                cos_addr = r_ext;
                neg_sin  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/twiddle_rom_arbiter.sv
// Round-robin arbiter sharing a single-port quarter-wave sine ROM between two
// requesters; each request costs two ROM reads and returns Q1.15 cos/sin.
// Optional feature macro: TWIDDLE_CONJ_EN (adds per-request sin conjugation).
import twiddle_pkg::*;

module twiddle_rom_arbiter (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [PHASE_W-1:0]    req0_phase,
    output logic                  rsp0_valid,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [PHASE_W-1:0]    req1_phase,
    output logic                  rsp1_valid,
`ifdef TWIDDLE_CONJ_EN
    input  logic                  req0_conj,
    input  logic                  req1_conj,
`endif
    output logic [DATA_W-1:0]     rsp_cos,
    output logic [DATA_W-1:0]     rsp_sin,
    output logic                  rom_ce,
    output logic [ROM_ADDR_W-1:0] rom_ad,
    input  logic [DATA_W-1:0]     rom_dout
);

    state_e                state_q, state_d;
    logic                  run_q, run_d;
    logic                  last_grant_q, last_grant_d;
    logic                  grant_q, grant_d;
    logic [PHASE_W-1:0]    phase_q, phase_d;
    logic [DATA_W-1:0]     raw_sin_q, raw_sin_d;
    logic [DATA_W-1:0]     rsp_cos_q, rsp_cos_d;
    logic [DATA_W-1:0]     rsp_sin_q, rsp_sin_d;
    logic                  rsp0_valid_q, rsp0_valid_d;
    logic                  rsp1_valid_q, rsp1_valid_d;
    logic                  rom_ce_q, rom_ce_d;
    logic [ROM_ADDR_W-1:0] rom_ad_q, rom_ad_d;

    logic                  grant_sel;
    logic                  accept;
    logic [PHASE_W-1:0]    sel_phase;
    logic [PHASE_W-1:0]    map_phase;
    logic [ROM_ADDR_W-1:0] map_sin_addr;
    logic [ROM_ADDR_W-1:0] map_cos_addr;
    logic                  map_neg_sin;
    logic                  map_neg_cos;
    logic                  sin_neg;

`ifdef TWIDDLE_CONJ_EN
    logic                  conj_q, conj_d;
    logic                  sel_conj;
    assign sel_conj = grant_sel ? req1_conj : req0_conj;
    assign sin_neg  = map_neg_sin ^ conj_q;
`else
    assign sin_neg  = map_neg_sin;
`endif

    // Round-robin pick: on contention favour the requester not served last.
    // run_q keeps ready low until the first edge after reset release.
    always_comb begin
        if (req0_valid && req1_valid) grant_sel = ~last_grant_q;
        else                          grant_sel = req1_valid;
    end

    assign req0_ready = run_q && (state_q == IDLE) && req0_valid && !grant_sel;
    assign req1_ready = run_q && (state_q == IDLE) && req1_valid &&  grant_sel;
    assign accept     = req0_ready || req1_ready;
    assign sel_phase  = grant_sel ? req1_phase : req0_phase;

    // In IDLE the map looks at the incoming phase so the sin address can be
    // registered on the accept edge; afterwards it follows the latched phase.
    assign map_phase = (state_q == IDLE) ? sel_phase : phase_q;

    twiddle_quadrant_map u_map (
        .phase    (map_phase),
        .sin_addr (map_sin_addr),
        .cos_addr (map_cos_addr),
        .neg_sin  (map_neg_sin),
        .neg_cos  (map_neg_cos)
    );

    // Next-state and registered-output logic for the four-cycle read sequence
    always_comb begin
        state_d      = state_q;
        run_d        = 1'b1;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        phase_d      = phase_q;
        raw_sin_d    = raw_sin_q;
        rsp_cos_d    = rsp_cos_q;
        rsp_sin_d    = rsp_sin_q;
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        rom_ce_d     = rom_ce_q;
        rom_ad_d     = rom_ad_q;
`ifdef TWIDDLE_CONJ_EN
        conj_d       = conj_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    phase_d      = sel_phase;
                    grant_d      = grant_sel;
                    last_grant_d = grant_sel;
                    rom_ce_d     = 1'b1;
                    rom_ad_d     = map_sin_addr;
                    state_d      = RD_A;
`ifdef TWIDDLE_CONJ_EN
                    conj_d       = sel_conj;
`endif
                end
            end
            RD_A: begin
                rom_ce_d = 1'b1;
                rom_ad_d = map_cos_addr;
                state_d  = RD_B;
            end
            RD_B: begin
                raw_sin_d = rom_dout;
                rom_ce_d  = 1'b0;
                state_d   = CAP;
            end
            CAP: begin
                rsp_cos_d    = cond_neg(rom_dout, map_neg_cos);
                rsp_sin_d    = cond_neg(raw_sin_q, sin_neg);
                rsp0_valid_d = !grant_q;
                rsp1_valid_d =  grant_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops any in-flight response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            run_q        <= 1'b0;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            phase_q      <= '0;
            raw_sin_q    <= '0;
            rsp_cos_q    <= '0;
            rsp_sin_q    <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rom_ce_q     <= 1'b0;
            rom_ad_q     <= '0;
`ifdef TWIDDLE_CONJ_EN
            conj_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            run_q        <= run_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            phase_q      <= phase_d;
            raw_sin_q    <= raw_sin_d;
            rsp_cos_q    <= rsp_cos_d;
            rsp_sin_q    <= rsp_sin_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rom_ce_q     <= rom_ce_d;
            rom_ad_q     <= rom_ad_d;
`ifdef TWIDDLE_CONJ_EN
            conj_q       <= conj_d;
`endif
        end
    end

    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp_cos    = rsp_cos_q;
    assign rsp_sin    = rsp_sin_q;
    assign rom_ce     = rom_ce_q;
    assign rom_ad     = rom_ad_q;

endmodule

// File: tb/tb_twiddle_rom_arbiter.sv
// Directed bench for twiddle_rom_arbiter with a behavioural quarter-wave ROM.
module tb_twiddle_rom_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [11:0] req0_phase = '0, req1_phase = '0;
    logic        rsp0_valid, rsp1_valid;
    logic        conj0 = 1'b0, conj1 = 1'b0;
    logic [15:0] rsp_cos, rsp_sin;
    logic        rom_ce;
    logic [10:0] rom_ad;
    logic [15:0] rom_dout = '0;
    logic [15:0] rom [0:1024];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    twiddle_rom_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_phase (req0_phase),
        .rsp0_valid (rsp0_valid),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_phase (req1_phase),
        .rsp1_valid (rsp1_valid),
`ifdef TWIDDLE_CONJ_EN
        .req0_conj  (conj0),
        .req1_conj  (conj1),
`endif
        .rsp_cos    (rsp_cos),
        .rsp_sin    (rsp_sin),
        .rom_ce     (rom_ce),
        .rom_ad     (rom_ad),
        .rom_dout   (rom_dout)
    );

    // Quarter-wave table T[x] = round(32767 * sin(pi/2 * x/1024)), registered read
    initial begin
        for (int i = 0; i <= 1024; i++)
            rom[i] = 16'($rtoi(32767.0 * $sin(3.14159265358979 / 2.0 * i / 1024.0) + 0.5));
    end

    always @(posedge clk) if (rom_ce) rom_dout <= rom[rom_ad];

    // Issue one request, follow it through the ROM reads and check the result
    task automatic do_req(input logic id, input logic [11:0] ph, input logic cj,
                          input logic [10:0] exp_sa, input logic [10:0] exp_ca,
                          input logic [15:0] exp_cos, input logic [15:0] exp_sin,
                          input string nm);
        int n;
        @(negedge clk);
        if (id) begin req1_valid = 1'b1; req1_phase = ph; conj1 = cj; end
        else    begin req0_valid = 1'b1; req0_phase = ph; conj0 = cj; end
        #1;
        n = 0;
        while (!(id ? req1_ready : req0_ready) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL %s ready: got 0 after %0d cycles, required 1", nm, n);
            req0_valid = 1'b0; req1_valid = 1'b0;
            return;
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        checks++;
        if (rom_ce !== 1'b1 || rom_ad !== exp_sa) begin
            errors++;
            $display("FAIL %s rd_a: ce=%b ad=%h, required ce=1 ad=%h", nm, rom_ce, rom_ad, exp_sa);
        end
        @(negedge clk); #1;
        checks++;
        if (rom_ce !== 1'b1 || rom_ad !== exp_ca) begin
            errors++;
            $display("FAIL %s rd_b: ce=%b ad=%h, required ce=1 ad=%h", nm, rom_ce, rom_ad, exp_ca);
        end
        @(negedge clk); #1;
        checks++;
        if (rom_ce !== 1'b0 || rom_ad !== exp_ca || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s cap: ce=%b ad=%h v0=%b v1=%b, required ce=0 ad=%h v=0",
                     nm, rom_ce, rom_ad, rsp0_valid, rsp1_valid, exp_ca);
        end
        @(negedge clk); #1;
        checks++;
        if (rsp0_valid !== !id || rsp1_valid !== id || rsp_cos !== exp_cos || rsp_sin !== exp_sin) begin
            errors++;
            $display("FAIL %s rsp: v0=%b v1=%b cos=%h sin=%h, required v%0d cos=%h sin=%h",
                     nm, rsp0_valid, rsp1_valid, rsp_cos, rsp_sin, id, exp_cos, exp_sin);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (req0_ready !== 0 || req1_ready !== 0 || rsp0_valid !== 0 || rsp1_valid !== 0 ||
            rsp_cos !== 16'h0 || rsp_sin !== 16'h0 || rom_ce !== 0 || rom_ad !== 11'h0) begin
            errors++;
            $display("FAIL reset: rdy=%b%b v=%b%b cos=%h sin=%h ce=%b ad=%h, required all 0",
                     req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_cos, rsp_sin, rom_ce, rom_ad);
        end
        rst_n = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL first_ready: rdy0=%b rdy1=%b, required 1 0", req0_ready, req1_ready);
        end
        req0_valid = 1'b0;
        #1;
        checks++;
        if (req0_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_follows_valid: rdy0=%b, required 0", req0_ready);
        end
    endtask

    task automatic test_quadrants();
        do_req(1'b0, 12'h000, 1'b0, 11'h000, 11'h400, 16'h7fff, 16'h0000, "ph000");
        do_req(1'b0, 12'h400, 1'b0, 11'h400, 11'h000, 16'h0000, 16'h7fff, "ph400");
        do_req(1'b0, 12'h800, 1'b0, 11'h000, 11'h400, 16'h8001, 16'h0000, "ph800");
        do_req(1'b1, 12'hC00, 1'b0, 11'h400, 11'h000, 16'h0000, 16'h8001, "phC00");
        do_req(1'b0, 12'h001, 1'b0, 11'h001, 11'h3ff, 16'h7fff, 16'h0032, "ph001");
        do_req(1'b1, 12'hFFF, 1'b0, 11'h001, 11'h3ff, 16'h7fff, 16'hffce, "phFFF");
        @(negedge clk); #1;
        checks++;
        if (rsp1_valid !== 1'b0 || rsp_cos !== 16'h7fff || rsp_sin !== 16'hffce) begin
            errors++;
            $display("FAIL hold: v1=%b cos=%h sin=%h, required 0 7fff ffce", rsp1_valid, rsp_cos, rsp_sin);
        end
    endtask

    task automatic test_back_to_back();
        logic e_r0, e_r1, e_v0, e_v1;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        req0_phase = 12'h000; req1_phase = 12'h400;
        req0_valid = 1'b1;    req1_valid = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            e_r0 = (c % 4 == 0) && ((c / 4) % 2 == 0);
            e_r1 = (c % 4 == 0) && ((c / 4) % 2 == 1);
            e_v0 = (c > 0) && (c % 4 == 0) && ((c / 4) % 2 == 1);
            e_v1 = (c > 0) && (c % 4 == 0) && ((c / 4) % 2 == 0);
            checks++;
            if (req0_ready !== e_r0 || req1_ready !== e_r1 || rsp0_valid !== e_v0 || rsp1_valid !== e_v1) begin
                errors++;
                $display("FAIL rr_cycle%0d: rdy=%b%b v=%b%b, required rdy=%b%b v=%b%b",
                         c, req0_ready, req1_ready, rsp0_valid, rsp1_valid, e_r0, e_r1, e_v0, e_v1);
            end
            if (e_v0 || e_v1) begin
                checks++;
                if (rsp_cos !== (e_v0 ? 16'h7fff : 16'h0000) || rsp_sin !== (e_v0 ? 16'h0000 : 16'h7fff)) begin
                    errors++;
                    $display("FAIL rr_data%0d: cos=%h sin=%h", c, rsp_cos, rsp_sin);
                end
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n;
        @(negedge clk);
        req0_valid = 1'b1; req0_phase = 12'h800;
        #1;
        n = 0;
        while (!req0_ready && n < 20) begin @(negedge clk); #1; n++; end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL mid_ready: got 0, required 1");
        end
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (rom_ce !== 1'b1) begin
            errors++;
            $display("FAIL mid_rd_b: ce=%b, required 1", rom_ce);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (rom_ce !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: ce=%b v=%b%b, required 0 00", rom_ce, rsp0_valid, rsp1_valid);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) n++;
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL mid_drop: %0d cycles with rsp valid, required 0", n);
        end
        do_req(1'b1, 12'h400, 1'b0, 11'h400, 11'h000, 16'h0000, 16'h7fff, "post_reset");
    endtask

    task automatic test_conj();
`ifdef TWIDDLE_CONJ_EN
        do_req(1'b0, 12'h400, 1'b1, 11'h400, 11'h000, 16'h0000, 16'h8001, "conj");
`else
        do_req(1'b0, 12'h400, 1'b1, 11'h400, 11'h000, 16'h0000, 16'h7fff, "conj");
`endif
    endtask

    initial begin
        test_reset();
        test_quadrants();
        test_back_to_back();
        test_reset_mid();
        test_conj();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/twiddle_rom_arbiter.md
Name: twiddle_rom_arbiter

Overview:
- Shares the single-port quarter-wave sine ROM (1025 entries × 16 bit, 11-bit address, index 1024 = 0x7fff) between two requesters, e.g. FFT butterfly and carrier NCO.
- Each request carries a 12-bit full-circle phase. The block returns signed Q1.15 cos and sin from two sequential ROM reads, applying quadrant symmetry.
- Sits between the OFDM datapath engines and the ROM wrapper.

Parameters:
- PHASE_W, 12, full-circle phase width (4096 steps); bits [11:10] are the quadrant, [9:0] the offset.
- DATA_W, 16, ROM/output sample width, two's complement.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has a phase
- req0_ready  out  1  requester 0 accepted this cycle when valid&ready
- req0_phase  in  PHASE_W  requester 0 phase
- rsp0_valid  out  1  one-cycle pulse, requester 0 result valid
- req1_valid / req1_ready / req1_phase / rsp1_valid  same as requester 0
- rsp_cos  out  DATA_W  shared result cos, qualified by rsp0_valid or rsp1_valid
- rsp_sin  out  DATA_W  shared result sin
- rom_ce  out  1  ROM clock enable
- rom_ad  out  11  ROM address
- rom_dout  in  DATA_W  ROM data, registered, valid 1 cycle after address sampled

Behaviour:
- Reset values: req*_ready=0, rsp*_valid=0, rsp_cos=0, rsp_sin=0, rom_ce=0, rom_ad=0, state=IDLE, last_grant=1.
- States: IDLE → RD_A → RD_B → CAP → IDLE.
- IDLE:
  - req*_ready=1 only for the granted requester, and only while its valid is high.
  - Round-robin: if both are valid, grant the one not equal to last_grant; if only one is valid, grant it.
  - On handshake, latch phase and grant id, update last_grant, go to RD_A.
- Quadrant map, with q=phase[11:10], r=phase[9:0], T[x]=ROM[x]:
  - q0: sin=T[r], cos=T[1024-r]
  - q1: sin=T[1024-r], cos=−T[r]
  - q2: sin=−T[r], cos=−T[1024-r]
  - q3: sin=−T[1024-r], cos=T[r]
- Address widths: 1024-r is computed in 11 bits (range 1..1024); r is zero-extended to 11 bits.
- RD_A: rom_ce=1, rom_ad=sin address.
- RD_B: rom_ce=1, rom_ad=cos address; capture rom_dout as raw sin.
- CAP: rom_ce=0; capture rom_dout as raw cos. Apply negation (two's complement; −0x7fff=0x8001, −0=0) into rsp_sin/rsp_cos. Pulse rsp<grant>_valid next cycle. Return to IDLE.
- Latency: accept edge to rsp_valid high = 4 cycles. Throughput is 1 request per 4 cycles; ready stays low outside IDLE.
- rsp_cos/rsp_sin hold their value until the next result. Responses are not backpressured; consumers must take them on the pulse.
- rom_ad holds its last value when rom_ce=0.
- A new request may be accepted in the same cycle rsp_valid pulses (IDLE re-entered).
- Reset mid-operation: immediately returns to reset values. The pending response is dropped, never pulsed. The first ready is possible on the first clk edge after rst_n deasserts.
- A requester dropping valid before the handshake is legal; no grant occurs.

Optional Feature:
- Macro TWIDDLE_CONJ_EN.
- When defined: adds ports req0_conj and req1_conj (in, 1), latched with the phase. When set, the final rsp_sin is negated (conjugate twiddle for IFFT); cos is unaffected.
- When undefined: these ports do not exist and no extra logic is present.

Decomposition:
- Package twiddle_pkg holds:
  - PHASE_W, DATA_W
  - ROM_ADDR_W=11, QUARTER=1024, ROM_PEAK=16'h7fff
  - quadrant localparams Q0..Q3
  - state encoding IDLE/RD_A/RD_B/CAP
- Sub-module twiddle_quadrant_map (combinational):
  - input: phase
  - outputs: sin_addr, cos_addr, neg_sin, neg_cos

Test Plan:
- req0 phase 0x000 → 4 cycles after accept: rsp0_valid=1, cos=0x7fff, sin=0x0000; rom_ad sequence 0x000, 0x400.
- Phases 0x400, 0x800, 0xC00:
  - 0x400 → cos=0x0000, sin=0x7fff
  - 0x800 → cos=0x8001, sin=0x0000
  - 0xC00 → cos=0x0000, sin=0x8001
- Phase 0x001 → sin=0x0032, cos=0x7fff. Phase 0xFFF → sin=0xffce, cos=0x7fff.
- After reset, req0 and req1 both valid continuously → grants alternate req0, req1, req0…; rsp0 pulses 4 cycles after its accept; req1 is accepted at the rsp0 cycle; rsp1 pulses 4 cycles later.
- rst_n asserted during RD_B → rsp*_valid never pulses, rom_ce=0 immediately. After release, req1 phase 0x400 completes normally with sin=0x7fff.
- TWIDDLE_CONJ_EN: req0 phase 0x400 with conj=1 → sin=0x8001, cos=0x0000. Without the macro, the same phase gives sin=0x7fff.
